multiplexer_2to1: RTL and testbench
===================================

# multiplexer_2to1

Registered 2:1 selector. One cycle after sampling, it forwards input `a` when `select` is 0, or input `b` when `select` is 1. A combinational copy of the selected value is also provided for paths that cannot afford the register stage. The block sits at the leaf level of the datapath, wherever a clocked two-way source choice is needed, and also counts select changes for debug visibility.

## Interface
Parameters:
- WIDTH, default 1, data width of `a`, `b`, `y` and `y_comb`; legal range 1..64.
- CNT_WIDTH, default 8, width of the select-transition counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- a  input  WIDTH  data source chosen when `select` = 0.
- b  input  WIDTH  data source chosen when `select` = 1.
- select  input  1  source select; 0 chooses `a`, 1 chooses `b`.
- in_valid  input  1  qualifies `a`, `b` and `select` for the current cycle.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  registered copy of `in_valid`; qualifies `y`.
- y_comb  output  WIDTH  combinational selected data, computed as `select ? b : a`.
- sel_toggles  output  CNT_WIDTH  count of `select` value changes seen on valid cycles; saturates at its maximum.

## Operation
- `y_comb` is purely combinational:
  - no dependence on `clk`, `rst` or `in_valid`;
  - follows any change on `a`, `b` or `select` within the same delta.
- Register stage, at each rising edge with `rst` = 0:
  - if `in_valid` = 1: `y` <= `select ? b : a`; `y_valid` <= 1;
  - if `in_valid` = 0: `y` holds its previous value; `y_valid` <= 0.
- Select tracking:
  - internal register `last_sel` is updated on valid cycles only;
  - on a valid cycle where `select` != `last_sel`, `sel_toggles` increments by 1;
  - the increment is suppressed once `sel_toggles` = 2^CNT_WIDTH-1 (saturation, no wrap);
  - the first valid cycle after reset compares against `last_sel` = 0.
- X/Z on `select`: no requirement on `y_comb`. The bench must not drive X on `select` during valid cycles.
- No handshake back-pressure: the block always accepts input.

## Timing
- Reset:
  - while `rst` = 1 at a rising edge: `y` <= 0, `y_valid` <= 0, `sel_toggles` <= 0, `last_sel` <= 0;
  - reset takes priority over `in_valid`;
  - reset mid-stream discards the in-flight value; `y` reads 0 on the cycle after the reset edge.
- Latency:
  - `y` / `y_valid`: exactly 1 cycle from the sampling edge;
  - `y_comb`: 0 cycles;
  - `sel_toggles`: visible 1 cycle after the valid edge on which the change was sampled.
- Back-to-back valid cycles give full throughput, one result per cycle.
- When `select`, `a` and `b` change together before the same edge, the edge samples all three together. The result uses the new `select` with the new data.
- Only inputs registered at the edge determine `y`. Changes between edges affect only `y_comb`.

## Test plan
- Reset: assert `rst` for 2 cycles with `a` = 1, `b` = 1, `in_valid` = 1 -> `y` = 0, `y_valid` = 0, `sel_toggles` = 0.
- Truth sequence (WIDTH = 1, `in_valid` = 1, one step per cycle):
  - step 1: `a` = 0, `b` = 0, `select` = 0 -> `y_comb` = 0, then `y` = 0;
  - step 2: `a` = 1 -> `y_comb` = 1 immediately; `y` = 1 next cycle;
  - step 3: `select` = 1 -> `y` = 0 (follows `b`);
  - step 4: `b` = 1 -> `y` = 1;
  - step 5: `a` = 0 -> `y` remains 1.
- Hold: `in_valid` = 0 while toggling `a`, `b` and `select` for 3 cycles -> `y` unchanged, `y_valid` = 0, `sel_toggles` unchanged; `y_comb` tracks the inputs.
- Counter:
  - CNT_WIDTH = 2, toggle `select` on 5 consecutive valid cycles -> `sel_toggles` goes 1, 2, 3, then holds at 3;
  - assert `rst` -> 0.
- Wide data: WIDTH = 8, `a` = 0xA5, `b` = 0x3C; alternate `select` 0/1 on valid cycles -> `y` alternates 0xA5 / 0x3C with 1-cycle delay.
- Reset mid-stream: valid `b` = 1 with `select` = 1, and `rst` = 1 on the same edge -> `y` = 0 and `y_valid` = 0 on the following cycle.

Source files
------------

// File: rtl/multiplexer_2to1_if.sv
// multiplexer_2to1_if
//   Bundles the data/select/valid inputs and the selected outputs of
//   multiplexer_2to1.
//   master : drives a, b, select, in_valid; observes y, y_valid, y_comb, sel_toggles
//   slave  : the selector itself (inputs and outputs mirrored)
//   WIDTH     : data width of a, b, y, y_comb (1..64)
//   CNT_WIDTH : width of the select-transition counter
interface multiplexer_2to1_if #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 select;
  logic                 in_valid;
  logic [WIDTH-1:0]     y;
  logic                 y_valid;
  logic [WIDTH-1:0]     y_comb;
  logic [CNT_WIDTH-1:0] sel_toggles;

  modport master (
    output a, b, select, in_valid,
    input  y, y_valid, y_comb, sel_toggles
  );

  modport slave (
    input  a, b, select, in_valid,
    output y, y_valid, y_comb, sel_toggles
  );
endinterface

// File: rtl/multiplexer_2to1.sv
// multiplexer_2to1
//   Registered 2:1 selector with a combinational bypass copy and a
//   saturating counter of select changes for debug visibility.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : multiplexer_2to1_if.slave
//         a, b, select, in_valid -> y (1-cycle), y_valid, y_comb (0-cycle),
//         sel_toggles (count of select changes on valid cycles, saturating)
module multiplexer_2to1 #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  multiplexer_2to1_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     sel_data_s;
  logic                 toggle_s;
  logic [WIDTH-1:0]     y_r;
  logic                 y_valid_r;
  logic [CNT_WIDTH-1:0] sel_toggles_r;
  logic                 last_sel_r;

  // Selected data, shared by the bypass output and the register stage.
  always_comb begin
    sel_data_s = bus.a;
    if (bus.select == 1'b1) begin
      sel_data_s = bus.b;
    end else begin
      sel_data_s = bus.a;
    end
  end

  // Counter step: a valid select change while the counter is not yet at its ceiling.
  always_comb begin
    toggle_s = 1'b0;
    if (bus.in_valid && (bus.select != last_sel_r) && (sel_toggles_r != CNT_MAX)) begin
      toggle_s = 1'b1;
    end else begin
      toggle_s = 1'b0;
    end
  end

  // Register stage and select tracking; y holds across invalid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r           <= {WIDTH{1'b0}};
      y_valid_r     <= 1'b0;
      sel_toggles_r <= {CNT_WIDTH{1'b0}};
      last_sel_r    <= 1'b0;
    end else begin
      y_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        y_r        <= sel_data_s;
        last_sel_r <= bus.select;
        if (toggle_s) begin
          sel_toggles_r <= sel_toggles_r + CNT_ONE;
        end
      end
    end
  end

  assign bus.y           = y_r;
  assign bus.y_valid     = y_valid_r;
  assign bus.y_comb      = sel_data_s;
  assign bus.sel_toggles = sel_toggles_r;

endmodule

// File: tb/tb_multiplexer_2to1.sv
module tb_multiplexer_2to1;

  typedef struct packed {
    logic [7:0] y;
    logic       yv;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst1;
  logic rst8;
  int   n_checks;
  int   n_fails;

  exp_t sb1[$];
  exp_t sb8[$];

  // bench-side reference state for each instance
  logic       m1_y, m1_yv, m1_last;
  logic [1:0] m1_cnt;
  logic [7:0] m8_y, m8_cnt;
  logic       m8_yv, m8_last;

  multiplexer_2to1_if #(.WIDTH(1), .CNT_WIDTH(2)) bus1 ();
  multiplexer_2to1_if #(.WIDTH(8), .CNT_WIDTH(8)) bus8 ();

  multiplexer_2to1 #(.WIDTH(1), .CNT_WIDTH(2)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
  multiplexer_2to1 #(.WIDTH(8), .CNT_WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of stimulus on the 1-bit instance and push what should appear after the edge
  task automatic drive1(input logic a, input logic b, input logic sel, input logic v, input logic r);
    exp_t e;
    bus1.a = a; bus1.b = b; bus1.select = sel; bus1.in_valid = v; rst1 = r;
    if (r) begin
      m1_y = 1'b0; m1_yv = 1'b0; m1_cnt = 2'd0; m1_last = 1'b0;
    end else if (v) begin
      m1_y  = sel ? b : a;
      m1_yv = 1'b1;
      if ((sel != m1_last) && (m1_cnt != 2'd3)) m1_cnt = m1_cnt + 2'd1;
      m1_last = sel;
    end else begin
      m1_yv = 1'b0;
    end
    e.y = {7'd0, m1_y}; e.yv = m1_yv; e.cnt = {6'd0, m1_cnt};
    sb1.push_back(e);
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sel, input logic v, input logic r);
    exp_t e;
    bus8.a = a; bus8.b = b; bus8.select = sel; bus8.in_valid = v; rst8 = r;
    if (r) begin
      m8_y = 8'd0; m8_yv = 1'b0; m8_cnt = 8'd0; m8_last = 1'b0;
    end else if (v) begin
      m8_y  = sel ? b : a;
      m8_yv = 1'b1;
      if ((sel != m8_last) && (m8_cnt != 8'hFF)) m8_cnt = m8_cnt + 8'd1;
      m8_last = sel;
    end else begin
      m8_yv = 1'b0;
    end
    e.y = m8_y; e.yv = m8_yv; e.cnt = m8_cnt;
    sb8.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      if (sb1.size() == 0) begin n_checks++; n_fails++; $display("FAIL reset_sb empty"); end
      else begin
        e = sb1.pop_front();
        n_checks++; if (bus1.y !== 1'b0) begin n_fails++; $display("FAIL reset_y got=%b exp=0", bus1.y); end
        n_checks++; if (bus1.y_valid !== 1'b0) begin n_fails++; $display("FAIL reset_yv got=%b exp=0", bus1.y_valid); end
        n_checks++; if (bus1.sel_toggles !== 2'd0) begin n_fails++; $display("FAIL reset_cnt got=%0d exp=0", bus1.sel_toggles); end
        n_checks++; if (bus1.y !== e.y[0]) begin n_fails++; $display("FAIL reset_sb_y got=%b exp=%b", bus1.y, e.y[0]); end
      end
    end
  endtask

  task automatic test_truth();
    exp_t e;
    logic [2:0] tab [5] = '{3'b000, 3'b100, 3'b101, 3'b111, 3'b011}; // {a,b,sel}
    logic       y_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive1(tab[i][2], tab[i][1], tab[i][0], 1'b1, 1'b0);
      #1;
      n_checks++;
      if (bus1.y_comb !== y_tab[i]) begin n_fails++; $display("FAIL truth_ycomb step=%0d got=%b exp=%b", i+1, bus1.y_comb, y_tab[i]); end
      @(posedge clk); #1;
      if (sb1.size() == 0) begin n_checks++; n_fails++; $display("FAIL truth_sb empty"); end
      else begin
        e = sb1.pop_front();
        n_checks++; if (bus1.y !== e.y[0]) begin n_fails++; $display("FAIL truth_y step=%0d got=%b exp=%b", i+1, bus1.y, e.y[0]); end
        n_checks++; if (bus1.y !== y_tab[i]) begin n_fails++; $display("FAIL truth_ytab step=%0d got=%b exp=%b", i+1, bus1.y, y_tab[i]); end
        n_checks++; if (bus1.y_valid !== e.yv) begin n_fails++; $display("FAIL truth_yv step=%0d got=%b exp=%b", i+1, bus1.y_valid, e.yv); end
        n_checks++; if (bus1.sel_toggles !== e.cnt[1:0]) begin n_fails++; $display("FAIL truth_cnt step=%0d got=%0d exp=%0d", i+1, bus1.sel_toggles, e.cnt[1:0]); end
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [2:0] tab [3] = '{3'b100, 3'b011, 3'b110}; // {a,b,sel}
    logic       exp_c;
    for (int i = 0; i < 3; i++) begin
      drive1(tab[i][2], tab[i][1], tab[i][0], 1'b0, 1'b0);
      exp_c = tab[i][0] ? tab[i][1] : tab[i][2];
      #1;
      n_checks++;
      if (bus1.y_comb !== exp_c) begin n_fails++; $display("FAIL hold_ycomb i=%0d got=%b exp=%b", i, bus1.y_comb, exp_c); end
      @(posedge clk); #1;
      if (sb1.size() == 0) begin n_checks++; n_fails++; $display("FAIL hold_sb empty"); end
      else begin
        e = sb1.pop_front();
        n_checks++; if (bus1.y !== 1'b1) begin n_fails++; $display("FAIL hold_y i=%0d got=%b exp=1", i, bus1.y); end
        n_checks++; if (bus1.y_valid !== 1'b0) begin n_fails++; $display("FAIL hold_yv i=%0d got=%b exp=0", i, bus1.y_valid); end
        n_checks++; if (bus1.sel_toggles !== e.cnt[1:0]) begin n_fails++; $display("FAIL hold_cnt i=%0d got=%0d exp=%0d", i, bus1.sel_toggles, e.cnt[1:0]); end
      end
    end
  endtask

  task automatic test_counter();
    exp_t e;
    logic [1:0] cnt_tab [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 7; i++) begin
      // step 0 clears, steps 1..5 alternate select starting at 1, step 6 resets
      if (i == 0 || i == 6) drive1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      else                  drive1(1'b0, 1'b1, i[0], 1'b1, 1'b0);
      @(posedge clk); #1;
      if (sb1.size() == 0) begin n_checks++; n_fails++; $display("FAIL cnt_sb empty"); end
      else begin
        e = sb1.pop_front();
        n_checks++; if (bus1.sel_toggles !== cnt_tab[i]) begin n_fails++; $display("FAIL cnt_tab i=%0d got=%0d exp=%0d", i, bus1.sel_toggles, cnt_tab[i]); end
        n_checks++; if (bus1.sel_toggles !== e.cnt[1:0]) begin n_fails++; $display("FAIL cnt_sb i=%0d got=%0d exp=%0d", i, bus1.sel_toggles, e.cnt[1:0]); end
        n_checks++; if (bus1.y !== e.y[0]) begin n_fails++; $display("FAIL cnt_y i=%0d got=%b exp=%b", i, bus1.y, e.y[0]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b0, 1'b1, 1'b1, 1'b1, i[0]);
      @(posedge clk); #1;
      if (sb1.size() == 0) begin n_checks++; n_fails++; $display("FAIL mid_sb empty"); end
      else begin
        e = sb1.pop_front();
        n_checks++; if (bus1.y !== e.y[0]) begin n_fails++; $display("FAIL mid_y i=%0d got=%b exp=%b", i, bus1.y, e.y[0]); end
        n_checks++; if (bus1.y_valid !== e.yv) begin n_fails++; $display("FAIL mid_yv i=%0d got=%b exp=%b", i, bus1.y_valid, e.yv); end
        n_checks++; if (bus1.sel_toggles !== e.cnt[1:0]) begin n_fails++; $display("FAIL mid_cnt i=%0d got=%0d exp=%0d", i, bus1.sel_toggles, e.cnt[1:0]); end
      end
    end
    n_checks++; if (bus1.y !== 1'b0) begin n_fails++; $display("FAIL mid_final_y got=%b exp=0", bus1.y); end
  endtask

  task automatic test_wide_data();
    exp_t       e;
    logic [7:0] exp_c;
    logic [7:0] exp_y;
    drive8(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    void'(sb8.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive8(8'hA5, 8'h3C, i[0], 1'b1, 1'b0);
      exp_c = i[0] ? 8'h3C : 8'hA5;
      #1;
      n_checks++;
      if (bus8.y_comb !== exp_c) begin n_fails++; $display("FAIL wide_ycomb i=%0d got=%h exp=%h", i, bus8.y_comb, exp_c); end
      // disturb the selected source between edges, then restore before the edge
      if (i[0]) bus8.b = 8'hFF; else bus8.a = 8'hFF;
      #1;
      n_checks++;
      if (bus8.y_comb !== 8'hFF) begin n_fails++; $display("FAIL wide_glitch i=%0d got=%h exp=ff", i, bus8.y_comb); end
      bus8.a = 8'hA5; bus8.b = 8'h3C;
      @(posedge clk); #1;
      exp_y = i[0] ? 8'h3C : 8'hA5;
      if (sb8.size() == 0) begin n_checks++; n_fails++; $display("FAIL wide_sb empty"); end
      else begin
        e = sb8.pop_front();
        n_checks++; if (bus8.y !== exp_y) begin n_fails++; $display("FAIL wide_y i=%0d got=%h exp=%h", i, bus8.y, exp_y); end
        n_checks++; if (bus8.y_valid !== e.yv) begin n_fails++; $display("FAIL wide_yv i=%0d got=%b exp=%b", i, bus8.y_valid, e.yv); end
        n_checks++; if (bus8.sel_toggles !== e.cnt) begin n_fails++; $display("FAIL wide_cnt i=%0d got=%0d exp=%0d", i, bus8.sel_toggles, e.cnt); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst1 = 1'b1; rst8 = 1'b1;
    bus1.a = 1'b0; bus1.b = 1'b0; bus1.select = 1'b0; bus1.in_valid = 1'b0;
    bus8.a = 8'd0; bus8.b = 8'd0; bus8.select = 1'b0; bus8.in_valid = 1'b0;
    m1_y = 1'b0; m1_yv = 1'b0; m1_last = 1'b0; m1_cnt = 2'd0;
    m8_y = 8'd0; m8_yv = 1'b0; m8_last = 1'b0; m8_cnt = 8'd0;
    @(posedge clk); #1;
    test_reset();
    test_truth();
    test_hold();
    test_counter();
    test_reset_midstream();
    test_wide_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
